// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder arbiter.
// It holds the floating-point field widths and the arbiter state enum.
package fp_pkg;

    localparam int unsigned EXP_LEN      = 8;
    localparam int unsigned MANTISSA_LEN = 23;
    localparam int unsigned FP_W         = EXP_LEN + MANTISSA_LEN + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin winner selection.
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index of the requester that was granted most recently
//   winner     - one-hot winner; all zero when no request is active
//   valid      - high when at least one request is active
// The search begins one past last_grant and wraps around, so the previous
// winner has the lowest priority.
module rr_arbiter_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned LG_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [LG_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(last_grant) + off) % NUM_REQ;
            if (!valid && req[idx[LG_W-1:0]]) begin
                winner[idx[LG_W-1:0]] = 1'b1;
                valid                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Session arbiter that lets several requesters share NUM_LANES floating-point
// adders. One requester at a time owns every lane. Ownership is held while its
// req stays high. After release, the arbiter waits until all adders are idle
// before it grants the next requester in round-robin order.
// Ports:
//   clk, reset         - clock and asynchronous active-high reset
//   req / gnt          - level session request / registered one-hot grant
//   req_add_*          - per-requester, per-lane adder interface
//   add_*              - shared adder lanes (add_ready high = idle, sum valid)
//   busy               - arbiter is not in IDLE
//   start_violation    - sticky: a start arrived from a requester without grant
module fp_add_arbiter #(
    parameter int unsigned EXP_LEN      = fp_pkg::EXP_LEN,
    parameter int unsigned MANTISSA_LEN = fp_pkg::MANTISSA_LEN,
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned NUM_LANES    = 2,
    parameter int unsigned FP_W         = EXP_LEN + MANTISSA_LEN + 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_REQ-1:0]                        req,
    output logic [NUM_REQ-1:0]                        gnt,
    input  logic [NUM_REQ-1:0][NUM_LANES-1:0]         req_add_start,
    input  logic [NUM_REQ-1:0][NUM_LANES-1:0][FP_W-1:0] req_add_a,
    input  logic [NUM_REQ-1:0][NUM_LANES-1:0][FP_W-1:0] req_add_b,
    output logic [NUM_REQ-1:0][NUM_LANES-1:0][FP_W-1:0] req_add_sum,
    output logic [NUM_REQ-1:0][NUM_LANES-1:0]         req_add_ready,
    output logic [NUM_LANES-1:0]                      add_start,
    output logic [NUM_LANES-1:0][FP_W-1:0]            add_a,
    output logic [NUM_LANES-1:0][FP_W-1:0]            add_b,
    input  logic [NUM_LANES-1:0][FP_W-1:0]            add_sum,
    input  logic [NUM_LANES-1:0]                      add_ready,
    output logic                                      busy,
    output logic                                      start_violation
);

    import fp_pkg::*;

    localparam int unsigned LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [LG_W-1:0]    last_grant_q, last_grant_d;
    logic               violation_q, violation_d;

    logic [NUM_REQ-1:0] winner;
    logic               win_valid;
    logic [LG_W-1:0]    win_idx;
    logic               all_ready;
    logic               stray_start;

    rr_arbiter_pick #(
        .NUM_REQ (NUM_REQ),
        .LG_W    (LG_W)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (winner),
        .valid      (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) win_idx = LG_W'(i);
        end
    end

    assign all_ready = &add_ready;

    // A start from a requester that does not hold the grant is flagged.
    // The lane mux already blocks it because the mux is qualified by gnt_q.
    always_comb begin
        stray_start = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_q[i] && (req_add_start[i] != '0)) stray_start = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        violation_d  = violation_q | stray_start;
        case (state_q)
            IDLE: begin
                if (win_valid && all_ready) begin
                    gnt_d        = winner;
                    last_grant_d = win_idx;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                if ((req & gnt_q) == '0) begin
                    gnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (all_ready) state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            last_grant_q <= LG_W'(NUM_REQ - 1);
            violation_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            violation_q  <= violation_d;
        end
    end

    // gnt_q is one-hot or zero, so OR-ing the masked requester buses gives a mux.
    always_comb begin
        add_start = '0;
        add_a     = '0;
        add_b     = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt_q[i]) begin
                    add_start[l] = add_start[l] | req_add_start[i][l];
                    add_a[l]     = add_a[l] | req_add_a[i][l];
                    add_b[l]     = add_b[l] | req_add_b[i][l];
                end
            end
        end
    end

    always_comb begin
        req_add_sum   = '0;
        req_add_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                req_add_ready[i][l] = add_ready[l] & gnt_q[i];
                if (gnt_q[i]) req_add_sum[i][l] = add_sum[l];
            end
        end
    end

    assign gnt             = gnt_q;
    assign busy            = (state_q != IDLE);
    assign start_violation = violation_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
module tb_fp_add_arbiter;

    localparam int NR = 3;
    localparam int NL = 2;
    localparam int W  = 32;

    logic                         clk;
    logic                         reset;
    logic [NR-1:0]                req;
    logic [NR-1:0]                gnt;
    logic [NR-1:0][NL-1:0]        req_add_start;
    logic [NR-1:0][NL-1:0][W-1:0] req_add_a;
    logic [NR-1:0][NL-1:0][W-1:0] req_add_b;
    logic [NR-1:0][NL-1:0][W-1:0] req_add_sum;
    logic [NR-1:0][NL-1:0]        req_add_ready;
    logic [NL-1:0]                add_start;
    logic [NL-1:0][W-1:0]         add_a;
    logic [NL-1:0][W-1:0]         add_b;
    logic [NL-1:0][W-1:0]         add_sum;
    logic [NL-1:0]                add_ready;
    logic                         busy;
    logic                         start_violation;

    int tests;
    int fails;
    int owner;
    int w;
    logic [NR-1:0] pat;

    fp_add_arbiter #(
        .EXP_LEN      (8),
        .MANTISSA_LEN (23),
        .NUM_REQ      (NR),
        .NUM_LANES    (NL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .gnt             (gnt),
        .req_add_start   (req_add_start),
        .req_add_a       (req_add_a),
        .req_add_b       (req_add_b),
        .req_add_sum     (req_add_sum),
        .req_add_ready   (req_add_ready),
        .add_start       (add_start),
        .add_a           (add_a),
        .add_b           (add_b),
        .add_sum         (add_sum),
        .add_ready       (add_ready),
        .busy            (busy),
        .start_violation (start_violation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    function automatic logic [NR-1:0] onehot(input int idx);
        logic [NR-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    // Reference round robin: the first active requester after the last winner, wrapping.
    function automatic int rr_next(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (r[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // Random lane traffic from the current owner, checked against the sharing rules.
    task automatic check_mux(input int own);
        for (int i = 0; i < NR; i++) begin
            for (int l = 0; l < NL; l++) begin
                req_add_a[i][l]     = $urandom;
                req_add_b[i][l]     = $urandom;
                req_add_start[i][l] = (i == own) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        for (int l = 0; l < NL; l++) begin
            add_sum[l]   = $urandom;
            add_ready[l] = 1'($urandom_range(0, 1));
        end
        #1;
        for (int l = 0; l < NL; l++) begin
            chk("mux_start", 32'(add_start[l]), (own >= 0) ? 32'(req_add_start[own][l]) : 32'd0);
            chk("mux_a", add_a[l], (own >= 0) ? req_add_a[own][l] : 32'd0);
            chk("mux_b", add_b[l], (own >= 0) ? req_add_b[own][l] : 32'd0);
            for (int i = 0; i < NR; i++) begin
                chk("rd_ready", 32'(req_add_ready[i][l]), (i == own) ? 32'(add_ready[l]) : 32'd0);
                chk("rd_sum", req_add_sum[i][l], (i == own) ? add_sum[l] : 32'd0);
            end
        end
        req_add_start = '0;
        add_ready     = '1;
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        reset         = 1'b1;
        req           = '0;
        req_add_start = '0;
        req_add_a     = '0;
        req_add_b     = '0;
        add_sum       = '0;
        add_ready     = 2'b11;
        #2;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_viol", 32'(start_violation), 32'd0);
        chk("rst_add_start", 32'(add_start), 32'd0);
        chk("rst_add_a0", add_a[0], 32'd0);
        tick();
        reset = 1'b0;

        // Single requester: 1.0 + 2.0 through lane 0.
        req = 3'b001;
        tick();
        chk("single_gnt", 32'(gnt), 32'b001);
        chk("single_busy", 32'(busy), 32'd1);
        req_add_a[0][0]     = 32'h3F800000;
        req_add_b[0][0]     = 32'h40000000;
        req_add_start[0][0] = 1'b1;
        #1;
        chk("single_start", 32'(add_start[0]), 32'd1);
        chk("single_a", add_a[0], 32'h3F800000);
        chk("single_b", add_b[0], 32'h40000000);
        tick();
        req_add_start[0][0] = 1'b0;
        add_ready[0]        = 1'b0;
        #1;
        chk("single_busy_rdy", 32'(req_add_ready[0][0]), 32'd0);
        add_ready[0] = 1'b1;
        add_sum[0]   = 32'h40400000;
        #1;
        chk("single_sum", req_add_sum[0][0], 32'h40400000);
        chk("single_rdy", 32'(req_add_ready[0][0]), 32'd1);
        for (int i = 1; i < NR; i++) begin
            for (int l = 0; l < NL; l++) begin
                chk("iso_ready", 32'(req_add_ready[i][l]), 32'd0);
                chk("iso_sum", req_add_sum[i][l], 32'd0);
            end
        end
        check_mux(0);
        req = 3'b000;
        tick();
        chk("rel_gnt", 32'(gnt), 32'd0);
        chk("rel_busy", 32'(busy), 32'd1);
        tick();
        chk("rel_idle", 32'(busy), 32'd0);

        // Contention from reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 3'b111;
        tick();
        chk("cont_g0", 32'(gnt), 32'b001);
        check_mux(0);
        req = 3'b110;
        tick();
        chk("cont_drain_gnt", 32'(gnt), 32'd0);
        chk("cont_drain_busy", 32'(busy), 32'd1);
        tick();
        chk("cont_idle_gnt", 32'(gnt), 32'd0);
        chk("cont_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("cont_g1", 32'(gnt), 32'b010);
        check_mux(1);

        // Start from a non-granted requester.
        req_add_start[2][1] = 1'b1;
        #1;
        chk("viol_blocked", 32'(add_start[1]), 32'd0);
        chk("viol_not_yet", 32'(start_violation), 32'd0);
        tick();
        req_add_start = '0;
        chk("viol_set", 32'(start_violation), 32'd1);

        // Requester 1 releases while lane 1 stays busy; requester 0 re-requests.
        add_ready[1] = 1'b0;
        req = 3'b101;
        tick();
        chk("drain_enter", 32'(busy), 32'd1);
        chk("drain_gnt", 32'(gnt), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("drain_hold_busy", 32'(busy), 32'd1);
            chk("drain_hold_gnt", 32'(gnt), 32'd0);
        end
        add_ready = 2'b11;
        tick();
        chk("drain_exit_busy", 32'(busy), 32'd0);
        tick();
        chk("cont_g2", 32'(gnt), 32'b100);
        check_mux(2);
        req = 3'b001;
        tick();
        tick();
        tick();
        chk("cont_g0_again", 32'(gnt), 32'b001);
        chk("viol_sticky", 32'(start_violation), 32'd1);

        // Reset in the middle of a session while the adders are busy.
        add_ready = 2'b00;
        req       = 3'b111;
        reset     = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_viol", 32'(start_violation), 32'd0);
        chk("mid_rst_start", 32'(add_start), 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mid_rst_wait_gnt", 32'(gnt), 32'd0);
            chk("mid_rst_wait_busy", 32'(busy), 32'd0);
        end
        add_ready = 2'b11;
        tick();
        chk("mid_rst_g0", 32'(gnt), 32'b001);

        // Random sessions checked against the round-robin reference.
        owner = 0;
        for (int n = 0; n < 20; n++) begin
            check_mux(owner);
            pat = 3'($urandom_range(0, 7));
            pat[owner] = 1'b0;
            req = pat;
            tick();
            chk("rnd_drain_gnt", 32'(gnt), 32'd0);
            chk("rnd_drain_busy", 32'(busy), 32'd1);
            req = 3'($urandom_range(1, 7));
            tick();
            chk("rnd_idle_busy", 32'(busy), 32'd0);
            tick();
            w = rr_next(req, owner);
            chk("rnd_gnt", 32'(gnt), 32'(onehot(w)));
            owner = w;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 SHALL take parameters: EXP_LEN, default 8, exponent width; MANTISSA_LEN, default 23, mantissa width; NUM_REQ, default 3, requester count; NUM_LANES, default 2, shared adder count; FP_W = EXP_LEN+MANTISSA_LEN+1.
REQ-002 SHALL have one clock; reset is asynchronous and active-high; ports: clk  in  1  clock; reset  in  1  async active-high reset.
REQ-003 SHALL have ports: req  in  [NUM_REQ]  level request, held for the whole session; gnt  out  [NUM_REQ]  registered one-hot grant.
REQ-004 SHALL have ports: req_add_start  in  [NUM_REQ][NUM_LANES]x1; req_add_a, req_add_b  in  [NUM_REQ][NUM_LANES]xFP_W; req_add_sum  out  [NUM_REQ][NUM_LANES]xFP_W; req_add_ready  out  [NUM_REQ][NUM_LANES]x1.
REQ-005 SHALL have ports: add_start  out  [NUM_LANES]x1; add_a, add_b  out  [NUM_LANES]xFP_W; add_sum  in  [NUM_LANES]xFP_W; add_ready  in  [NUM_LANES]x1 (high = adder idle, sum valid).
REQ-006 SHALL have ports: busy  out  1  state != IDLE; start_violation  out  1  sticky error flag.

Function
REQ-007 SHALL implement states IDLE, GRANT, DRAIN.
REQ-008 IDLE: if any req high and all add_ready high, SHALL register a one-hot gnt to the round-robin winner and go to GRANT at the next edge; otherwise stay in IDLE.
REQ-009 Round-robin: search SHALL start at last_grant+1 mod NUM_REQ; last_grant SHALL update on each grant.
REQ-010 GRANT: SHALL hold gnt while req[g] is high; when req[g] is low, SHALL clear gnt and go to DRAIN at the next edge.
REQ-011 DRAIN: SHALL go to IDLE on the first edge with all add_ready high; no gnt asserted.
REQ-012 Grant latency SHALL be 1 cycle from sampled req in IDLE. Back-to-back handoff SHALL take a minimum of 3 edges from release (DRAIN, IDLE, then new gnt).
REQ-013 add_start[l], add_a[l], add_b[l] SHALL be a combinational mux over requesters qualified by the registered gnt; with no gnt, SHALL drive 0.
REQ-014 req_add_ready[i][l] SHALL equal add_ready[l] & gnt[i].
REQ-015 req_add_sum[i][l] SHALL equal add_sum[l] when gnt[i], else 0.
REQ-016 Any req_add_start[i][l] high while gnt[i] is low SHALL set start_violation at the next edge and SHALL be blocked from add_start.
REQ-017 A requester that drops and reasserts req while others are waiting SHALL lose priority to them.
REQ-018 Simultaneous req, with none granted: SHALL apply the round-robin winner only; losers keep waiting with gnt low.

Reset
REQ-019 On reset: state=IDLE; gnt=0; last_grant=NUM_REQ-1 (requester 0 wins first); start_violation=0; busy=0; all add_* outputs 0.
REQ-020 Reset mid-session SHALL drop gnt immediately. After reset, no grant SHALL issue until all add_ready are high, which protects in-flight adder operations.

Structure
REQ-021 Shared package fp_pkg SHALL hold EXP_LEN, MANTISSA_LEN, FP_W and the arbiter state enum.
REQ-022 Round-robin winner selection SHALL be a combinational sub-module rr_arbiter_pick (inputs: req vector, last_grant; output: one-hot winner, valid).

Verification
REQ-023 Single requester: req[0]=1, lane0 a=32'h3F800000, b=32'h40000000, start pulse -> add_start[0] high the same cycle; req_add_sum[0][0]=32'h40400000 when ready.
REQ-024 Contention: req=3'b111 from reset -> grants in order 0,1,2,0. Each requester releases after one add. No two gnt bits are ever high together.
REQ-025 Drain: requester 1 releases while add_ready[1]=0 for 5 cycles -> DRAIN is held 5 cycles, then requester 2 is granted.
REQ-026 Violation: req_add_start[2][1]=1 with gnt[2]=0 -> add_start[1] stays 0 and start_violation=1, staying set until reset.
REQ-027 Reset mid-GRANT with add_ready=0 -> gnt=0 immediately. No grant issues until add_ready=2'b11, then gnt[0] is granted.
REQ-028 Isolation: while requester 0 is granted, req_add_ready[1]/[2]=0 and req_add_sum[1]/[2]=0 on all lanes.
